// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller.
//   state_e    : controller states
//   NUM_DIGITS : BCD digits in the time word (HH:MM:SS.cc)
//   DIGIT_W    : bits per BCD digit
//   digit_mod  : modulus of digit idx (0 = centiseconds ones ... 7 = hours tens)
package stopwatch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_STOP,
      ST_LAP_RUN,
      ST_LAP_STOP
   } state_e;

   localparam int unsigned NUM_DIGITS = 8;
   localparam int unsigned DIGIT_W    = 4;

   // Digit order c0 c1 S0 S1 M0 M1 H0 H1; only the tens of seconds/minutes are mod 6.
   function automatic int unsigned digit_mod(input int unsigned idx);
      case (idx)
         3, 5:    digit_mod = 6;
         default: digit_mod = 10;
      endcase
   endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the cascaded time counter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the digit (takes precedence over inc)
//   inc      : advance the digit this cycle
//   digit    : registered digit value, 0..MOD-1
//   carry    : combinational; high when inc would wrap the digit, feeds next digit's inc
module bcd_digit_counter #(
   parameter int unsigned MOD = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] digit,
   output logic       carry
);

   logic [3:0] digit_q, digit_d;

   // Same-cycle ripple: the whole chain settles before the edge.
   assign carry = inc && (digit_q == 4'(MOD - 1));

   always_comb begin
      digit_d = digit_q;
      if (clr)
         digit_d = '0;
      else if (inc)
         digit_d = carry ? 4'd0 : digit_q + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         digit_q <= '0;
      else
         digit_q <= digit_d;
   end

   assign digit = digit_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: prescaler, start/stop/lap/clear FSM, cascaded BCD
// time counter and lap-freeze display mux.
//   clk, rst      : clock, synchronous active-high reset
//   start_stop    : one-cycle pulse, toggles counting
//   lap           : one-cycle pulse, freezes / unfreezes the display
//   clear         : one-cycle pulse, zeroes the count when stopped
//   time_in_bcd   : HH:MM:SS.cc as 8 BCD digits, [31:28] = H1 ... [3:0] = c0
//   running       : counting (RUN, LAP_RUN)
//   lap_active    : display frozen on lap value (LAP_RUN, LAP_STOP)
//   overflow      : one-cycle pulse when the count wraps to zero
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 50_000_000,
   parameter int unsigned TICK_HZ = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_stop,
   input  logic        lap,
   input  logic        clear,
   output logic [31:0] time_in_bcd,
   output logic        running,
   output logic        lap_active,
   output logic        overflow
);

   localparam int unsigned DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned PW  = $clog2(DIV);

   state_e                                 state_q, state_d;
   logic [PW-1:0]                          presc_q, presc_d;
   logic [31:0]                            lap_reg_q, lap_reg_d;
   logic                                   overflow_q, overflow_d;
   logic                                   tick;
   logic                                   count_clr;
   logic [NUM_DIGITS-1:0][DIGIT_W-1:0]     digits;
   logic [NUM_DIGITS-1:0]                  digit_inc;
   logic [NUM_DIGITS-1:0]                  digit_carry;
   logic [31:0]                            count;

   assign running    = (state_q == ST_RUN) || (state_q == ST_LAP_RUN);
   assign lap_active = (state_q == ST_LAP_RUN) || (state_q == ST_LAP_STOP);
   assign tick       = running && (presc_q == PW'(DIV - 1));

   // ---------------- FSM ----------------
   // Priority clear > start_stop > lap; an input ignored in a state never
   // blocks a lower-priority one.
   always_comb begin
      state_d   = state_q;
      lap_reg_d = lap_reg_q;
      count_clr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_stop) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (start_stop) begin
               state_d = ST_STOP;
            end else if (lap) begin
               state_d   = ST_LAP_RUN;
               lap_reg_d = count;   // registered count = pre-increment value on a tick
            end
         end
         ST_STOP: begin
            if (clear) begin
               state_d   = ST_IDLE;
               count_clr = 1'b1;
            end else if (start_stop) begin
               state_d = ST_RUN;
            end
         end
         ST_LAP_RUN: begin
            if (start_stop)  state_d = ST_LAP_STOP;
            else if (lap)    state_d = ST_RUN;
         end
         ST_LAP_STOP: begin
            if (clear) begin
               state_d   = ST_IDLE;
               count_clr = 1'b1;
            end else if (start_stop) begin
               state_d = ST_LAP_RUN;
            end else if (lap) begin
               state_d = ST_STOP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- prescaler ----------------
   // Holds its phase while stopped so a resume continues mid-period.
   always_comb begin
      presc_d = presc_q;
      if (count_clr)
         presc_d = '0;
      else if (running)
         presc_d = tick ? '0 : presc_q + PW'(1);
   end

   assign overflow_d = tick && digit_carry[NUM_DIGITS-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         presc_q    <= '0;
         lap_reg_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         lap_reg_q  <= lap_reg_d;
         overflow_q <= overflow_d;
      end
   end

   // ---------------- BCD counter chain ----------------
   assign digit_inc = {digit_carry[NUM_DIGITS-2:0], tick};

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      bcd_digit_counter #(
         .MOD (digit_mod(i))
      ) u_digit (
         .clk   (clk),
         .rst   (rst),
         .clr   (count_clr),
         .inc   (digit_inc[i]),
         .digit (digits[i]),
         .carry (digit_carry[i])
      );
   end

   assign count       = digits;
   assign time_in_bcd = lap_active ? lap_reg_q : count;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl (DIV = 10). Reference model keeps the time as a
// plain centisecond integer and the controller as run/lap/idle flags.
module tb_stopwatch_ctrl;

   localparam int CLK_HZ  = 1000;
   localparam int TICK_HZ = 100;
   localparam int DIV     = CLK_HZ / TICK_HZ;
   localparam int MAX_CS  = 36_000_000 - 1;   // 99:59:59.99

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_stop = 1'b0;
   logic        lap = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] time_in_bcd;
   logic        running;
   logic        lap_active;
   logic        overflow;
   logic [7:0]  frc_mask = '0;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model state
   bit m_idle, m_run, m_lap, m_ovf;
   int m_cs, m_lapv, m_phase;

   stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_stop  (start_stop),
      .lap         (lap),
      .clear       (clear),
      .time_in_bcd (time_in_bcd),
      .running     (running),
      .lap_active  (lap_active),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] to_bcd(input int cs);
      int cc, s, m, h;
      cc = cs % 100;
      s  = (cs / 100) % 60;
      m  = (cs / 6000) % 60;
      h  = cs / 360000;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
              4'(s / 10), 4'(s % 10), 4'(cc / 10), 4'(cc % 10)};
   endfunction

   task automatic expect_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check(input string tag);
      logic [31:0] exp_t;
      exp_t = m_lap ? to_bcd(m_lapv) : to_bcd(m_cs);
      expect_val({tag, "_time"}, time_in_bcd, exp_t);
      expect_val({tag, "_running"}, {31'd0, running}, {31'd0, m_run});
      expect_val({tag, "_lap_active"}, {31'd0, lap_active}, {31'd0, m_lap});
      expect_val({tag, "_overflow"}, {31'd0, overflow}, {31'd0, m_ovf});
   endtask

   task automatic model_reset();
      m_idle = 1; m_run = 0; m_lap = 0; m_ovf = 0;
      m_cs = 0; m_lapv = 0; m_phase = 0;
   endtask

   // One clock: drive pulses, advance the model across the edge, check.
   task automatic step(input bit ss, input bit lp, input bit cl, input string tag);
      bit tick_now, run_old;
      @(negedge clk);
      start_stop = ss; lap = lp; clear = cl;
      @(posedge clk);
      run_old  = m_run;
      tick_now = m_run && (m_phase == DIV - 1);
      m_ovf    = tick_now && (m_cs == MAX_CS);
      if (cl && !m_idle && !m_run) begin
         m_idle = 1; m_lap = 0; m_cs = 0; m_phase = 0;
      end else if (ss) begin
         if (m_idle) begin m_idle = 0; m_run = 1; end
         else m_run = !m_run;
      end else if (lp && !m_idle && (m_run || m_lap)) begin
         if (m_lap) m_lap = 0;
         else begin m_lap = 1; m_lapv = m_cs; end
      end
      if (tick_now) m_cs = (m_cs == MAX_CS) ? 0 : m_cs + 1;
      if (run_old) m_phase = (m_phase + 1) % DIV;
      #1;
      check(tag);
   endtask

   task automatic do_reset(input bit ss, input bit lp, input bit cl);
      @(negedge clk);
      rst = 1'b1; start_stop = ss; lap = lp; clear = cl;
      @(posedge clk);
      model_reset();
      #1;
      check("reset");
      expect_val("reset_time_zero", time_in_bcd, 32'h0);
      @(negedge clk);
      rst = 1'b0; start_stop = 0; lap = 0; clear = 0;
   endtask

   // Load a time into a stopped, zeroed counter by pulsing each digit's
   // increment input directly, one digit at a time (no digit ever wraps).
   task automatic preload(input int cs);
      logic [31:0] b;
      int n;
      b = to_bcd(cs);
      for (int i = 0; i < 8; i++) begin
         n = int'(b[i*4 +: 4]);
         if (n > 0) begin
            @(negedge clk);
            frc_mask = 8'(1 << i);
            force dut.digit_inc = frc_mask;
            repeat (n) @(posedge clk);
            #1;
            release dut.digit_inc;
         end
      end
      m_cs = cs;
      check("preload");
   endtask

   initial begin
      model_reset();
      do_reset(0, 0, 0);
      expect_val("reset_flags", {29'd0, running, lap_active, overflow}, 32'd0);

      // 1: basic counting
      step(1, 0, 0, "t1_start");
      repeat (100) step(0, 0, 0, "t1_run");
      expect_val("t1_time", time_in_bcd, 32'h00000010);
      expect_val("t1_running", {31'd0, running}, 32'd1);

      // 2: carries into minutes and hours
      step(1, 0, 0, "t2_stop");
      step(0, 0, 1, "t2_clear");
      preload(5999);
      step(1, 0, 0, "t2_start");
      repeat (10) step(0, 0, 0, "t2_run");
      expect_val("t2_minute_carry", time_in_bcd, 32'h00010000);
      step(1, 0, 0, "t2b_stop");
      step(0, 0, 1, "t2b_clear");
      preload(359999);
      step(1, 0, 0, "t2b_start");
      repeat (10) step(0, 0, 0, "t2b_run");
      expect_val("t2_hour_carry", time_in_bcd, 32'h01000000);

      // 3: full wrap
      step(1, 0, 0, "t3_stop");
      step(0, 0, 1, "t3_clear");
      preload(MAX_CS);
      expect_val("t3_preload", time_in_bcd, 32'h99595999);
      step(1, 0, 0, "t3_start");
      repeat (10) step(0, 0, 0, "t3_run");
      expect_val("t3_wrap_time", time_in_bcd, 32'h0);
      expect_val("t3_overflow", {31'd0, overflow}, 32'd1);
      expect_val("t3_still_running", {31'd0, running}, 32'd1);
      step(0, 0, 0, "t3_after");
      expect_val("t3_overflow_pulse", {31'd0, overflow}, 32'd0);

      // 4: lap freeze
      step(1, 0, 0, "t4_stop");
      step(0, 0, 1, "t4_clear");
      step(1, 0, 0, "t4_start");
      repeat (50) step(0, 0, 0, "t4_run");
      expect_val("t4_pre_lap", time_in_bcd, 32'h00000005);
      step(0, 1, 0, "t4_lap");
      repeat (50) step(0, 0, 0, "t4_frozen");
      expect_val("t4_frozen_time", time_in_bcd, 32'h00000005);
      expect_val("t4_lap_active", {31'd0, lap_active}, 32'd1);
      step(0, 1, 0, "t4_unlap");
      expect_val("t4_live_time", time_in_bcd, 32'h00000010);

      // 5: clear handling
      step(0, 0, 1, "t5_clear_in_run");
      expect_val("t5_run_kept", {31'd0, running}, 32'd1);
      expect_val("t5_count_kept", time_in_bcd, 32'h00000010);
      step(1, 0, 0, "t5_stop");
      step(0, 0, 1, "t5_clear");
      expect_val("t5_cleared", time_in_bcd, 32'h0);
      step(1, 0, 0, "t5_start");
      repeat (25) step(0, 0, 0, "t5_run");
      step(1, 0, 0, "t5_stop2");
      step(1, 0, 1, "t5_clear_and_ss");
      expect_val("t5_priority_time", time_in_bcd, 32'h0);
      expect_val("t5_priority_run", {31'd0, running}, 32'd0);

      // 6: prescaler phase kept across stop, then reset mid-lap
      step(1, 0, 0, "t6_start");
      repeat (6) step(0, 0, 0, "t6_run");
      step(1, 0, 0, "t6_stop_at7");
      repeat (3) step(0, 0, 0, "t6_hold");
      step(1, 0, 0, "t6_resume");
      repeat (2) step(0, 0, 0, "t6_pre_tick");
      expect_val("t6_no_tick_yet", time_in_bcd, 32'h0);
      step(0, 0, 0, "t6_tick");
      expect_val("t6_first_tick", time_in_bcd, 32'h00000001);
      step(0, 1, 0, "t6_lap");
      repeat (5) step(0, 0, 0, "t6_laprun");
      do_reset(1, 1, 1);
      expect_val("t6_rst_flags", {29'd0, running, lap_active, overflow}, 32'd0);

      // random pulses against the model
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(0, 15);
         case (r)
            0:       step(1, 0, 0, "rnd");
            1:       step(0, 1, 0, "rnd");
            2:       step(0, 0, 1, "rnd");
            3:       step(1, 0, 1, "rnd");
            default: step(0, 0, 0, "rnd");
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
